collision_crash_manager: RTL and testbench
==========================================

Name: collision_crash_manager

Overview:
- Sits directly downstream of the AI car controller.
- Once per frame it consumes the AI car state vector and the player car state vector, and detects bounding-box overlap between the two.
- Runs the player crash / invulnerability / lives state machine.
- Outputs drive the player controller (freeze during crash), the renderer (blink during invulnerability) and the game-over screen.

Parameters:
- START_LIVES, 3, lives loaded at reset; legal range 1..7.
- CRASH_FRAMES, 60, frames spent in CRASH after a hit; minimum 1.
- INVULN_FRAMES, 90, frames spent in INVULN after CRASH; minimum 1.

Ports:
- clk  input  1  system clock
- resetN  input  1  asynchronous active-low reset
- frame_start  input  1  one-cycle strobe, once per video frame
- player_state  input  [0:4][0:10]  {img_id, x, y, width, height} of player car
- ai_state  input  [0:4][0:10]  {img_id, x, y, width, height} from AI car controller
- collision  output  1  one-cycle pulse when a hit is accepted
- crash_active  output  1  high while in CRASH
- invulnerable  output  1  high while in INVULN
- lives  output  3  remaining lives
- game_over  output  1  sticky high in GAME_OVER

Behaviour:
- Reset (async, resetN=0):
  - state=DRIVE, lives=START_LIVES, frame counter=0.
  - collision=0, crash_active=0, invulnerable=0, game_over=0.
  - Reset asserted mid-CRASH, INVULN or GAME_OVER returns to these values immediately.
- Sampling:
  - Inputs are evaluated only in the cycle where frame_start=1; all other cycles hold state.
  - All outputs are registered and change at the clock edge that samples frame_start (latency 1 cycle).
- Overlap (combinational, 12-bit unsigned arithmetic, no wrap):
  - hit = (P.x < A.x+A.w) && (A.x < P.x+P.w) && (P.y < A.y+A.h) && (A.y < P.y+P.h).
  - Strict compares: edges that only touch are not a hit.
  - A zero width or height on either car gives no hit.
  - ai_state img_id==0 means the AI car is inactive: hit forced 0.
- FSM, transitions on frame_start only:
  - DRIVE, hit and lives>1: lives-=1, collision pulse, counter=CRASH_FRAMES, go to CRASH.
  - DRIVE, hit and lives==1: lives=0, collision pulse, go to GAME_OVER.
  - DRIVE, no hit: stay.
  - CRASH: hits ignored. If counter==1, load counter=INVULN_FRAMES and go to INVULN; else counter-=1.
  - INVULN: hits ignored. If counter==1, go to DRIVE; else counter-=1.
  - GAME_OVER: absorbing until reset; hits ignored, no collision pulses.
- Output decode:
  - crash_active = (state==CRASH).
  - invulnerable = (state==INVULN).
  - game_over = (state==GAME_OVER).
  - collision is high for exactly one clk cycle, never during frames without frame_start.
- Timing: CRASH lasts exactly CRASH_FRAMES frame_start strobes after the hit frame; INVULN lasts exactly INVULN_FRAMES strobes.
- Counter width: 8 bits. Parameters above 255 are illegal and must be flagged by an elaboration-time assertion.
- lives never underflows below 0.
- Simultaneous events:
  - frame_start together with a hit and counter==1 in CRASH: the hit is ignored and the INVULN transition is taken.
  - A hit on the frame INVULN ends is ignored. The next frame in DRIVE evaluates normally.
  - Inputs changing between strobes have no effect.

Test Plan:
1. Reset, no frame_start for 100 cycles -> lives=3, all flags 0, collision never pulses.
2. P={1,256,380,32,36}, A={1,260,350,32,36}, one frame_start -> next cycle collision=1 for one cycle, crash_active=1, lives=2.
3. Touching edge, P as in 2 with A.y=344 (344+36=380) -> no collision. Same stimulus with A img_id=0 and full overlap -> no collision.
4. After the hit in 2, keep overlap for 60 frame_starts -> crash_active drops and invulnerable=1 on the 60th. After 90 more, state returns to DRIVE; the next overlapping frame gives a hit and lives=1.
5. START_LIVES=3, three hits separated by full crash+invuln periods -> lives 2,1,0. game_over=1 on the third hit with no CRASH entry; further overlaps give no pulse.
6. Assert resetN low mid-CRASH (counter=30) -> outputs return to reset values asynchronously, lives=3. Release and then overlap -> a normal hit is accepted.

Source files
------------

// File: rtl/collision_crash_manager.sv
// Player crash / invulnerability / lives controller. It checks player-vs-AI
// bounding-box overlap once per frame and steps the crash state machine on each frame strobe.
module collision_crash_manager #(
  parameter int START_LIVES   = 3,
  parameter int CRASH_FRAMES  = 60,
  parameter int INVULN_FRAMES = 90
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              frame_start,
  input  logic [0:4][0:10]  player_state,
  input  logic [0:4][0:10]  ai_state,
  output logic              collision,
  output logic              crash_active,
  output logic              invulnerable,
  output logic [2:0]        lives,
  output logic              game_over
);

  if (START_LIVES < 1 || START_LIVES > 7) begin : g_bad_lives
    $error("START_LIVES must be in 1..7");
  end
  if (CRASH_FRAMES < 1 || CRASH_FRAMES > 255) begin : g_bad_crash
    $error("CRASH_FRAMES must be in 1..255");
  end
  if (INVULN_FRAMES < 1 || INVULN_FRAMES > 255) begin : g_bad_invuln
    $error("INVULN_FRAMES must be in 1..255");
  end

  localparam logic [2:0] LIVES_INIT = 3'(START_LIVES);
  localparam logic [7:0] CRASH_CNT  = 8'(CRASH_FRAMES);
  localparam logic [7:0] INVULN_CNT = 8'(INVULN_FRAMES);

  typedef enum logic [1:0] {DRIVE, CRASH, INVULN, GAME_OVER} state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] lives_q, lives_d;
  logic       coll_q, coll_d;
  logic [1:0] axis_ov;
  logic       hit;
  logic       unused_player_img;

  assign unused_player_img = ^player_state[0];

  // Axis 0 = x (fields 1/3), axis 1 = y (fields 2/4). Sums are taken in 12 bits so they never wrap.
  for (genvar a = 0; a < 2; a++) begin : g_axis
    logic [11:0] p_lo, p_len, a_lo, a_len;
    assign p_lo  = {1'b0, player_state[1+a]};
    assign p_len = {1'b0, player_state[3+a]};
    assign a_lo  = {1'b0, ai_state[1+a]};
    assign a_len = {1'b0, ai_state[3+a]};
    assign axis_ov[a] = (p_len != 12'd0) && (a_len != 12'd0) &&
                        (p_lo < a_lo + a_len) && (a_lo < p_lo + p_len);
  end

  assign hit = (ai_state[0] != 11'd0) && (&axis_ov);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lives_d = lives_q;
    coll_d  = 1'b0;
    if (frame_start) begin
      unique case (state_q)
        DRIVE: begin
          if (hit) begin
            coll_d = 1'b1;
            if (lives_q > 3'd1) begin
              lives_d = lives_q - 3'd1;
              cnt_d   = CRASH_CNT;
              state_d = CRASH;
            end else begin
              lives_d = 3'd0;
              state_d = GAME_OVER;
            end
          end
        end
        CRASH: begin
          if (cnt_q == 8'd1) begin
            cnt_d   = INVULN_CNT;
            state_d = INVULN;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        INVULN: begin
          if (cnt_q == 8'd1) state_d = DRIVE;
          else               cnt_d = cnt_q - 8'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= DRIVE;
      cnt_q   <= 8'd0;
      lives_q <= LIVES_INIT;
      coll_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lives_q <= lives_d;
      coll_q  <= coll_d;
    end
  end

  assign collision    = coll_q;
  assign crash_active = (state_q == CRASH);
  assign invulnerable = (state_q == INVULN);
  assign game_over    = (state_q == GAME_OVER);
  assign lives        = lives_q;

endmodule

// File: tb/tb_collision_crash_manager.sv
// Scoreboard bench for collision_crash_manager: each frame strobe queues its expected
// outputs, and a monitor compares them on the cycle after the strobe.
module tb_collision_crash_manager;

  typedef logic [0:4][0:10] car_t;
  typedef struct packed {
    logic       coll;
    logic       crash;
    logic       inv;
    logic [2:0] lives;
    logic       go;
  } exp_t;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       frame_start = 1'b0;
  car_t       player_state, ai_state;
  logic       collision, crash_active, invulnerable, game_over;
  logic [2:0] lives;

  int n_cmp = 0;
  int n_bad = 0;
  exp_t exp_q[$];
  logic fs_cap = 1'b0;

  collision_crash_manager dut (
    .clk(clk), .resetN(resetN), .frame_start(frame_start),
    .player_state(player_state), .ai_state(ai_state),
    .collision(collision), .crash_active(crash_active), .invulnerable(invulnerable),
    .lives(lives), .game_over(game_over)
  );

  always #5 clk = ~clk;

  car_t P, A_HIT, A_TOUCH_Y, A_TOUCH_X, A_OFF, A_ZERO_W;
  initial begin
    P         = {11'd1, 11'd256, 11'd380, 11'd32, 11'd36};
    A_HIT     = {11'd1, 11'd260, 11'd350, 11'd32, 11'd36};
    A_TOUCH_Y = {11'd1, 11'd260, 11'd344, 11'd32, 11'd36};
    A_TOUCH_X = {11'd1, 11'd288, 11'd380, 11'd32, 11'd36};
    A_OFF     = {11'd0, 11'd256, 11'd380, 11'd32, 11'd36};
    A_ZERO_W  = {11'd1, 11'd256, 11'd380, 11'd0,  11'd36};
  end

  function automatic exp_t mk(input logic c, input logic cr, input logic iv,
                              input logic [2:0] l, input logic g);
    exp_t e;
    e.coll = c; e.crash = cr; e.inv = iv; e.lives = l; e.go = g;
    return e;
  endfunction

  task automatic cmp(input string name, input exp_t got, input exp_t want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got coll=%b crash=%b inv=%b lives=%0d go=%b, want coll=%b crash=%b inv=%b lives=%0d go=%b",
               name, got.coll, got.crash, got.inv, got.lives, got.go,
               want.coll, want.crash, want.inv, want.lives, want.go);
    end
  endtask

  function automatic exp_t snap();
    return mk(collision, crash_active, invulnerable, lives, game_over);
  endfunction

  always @(posedge clk) fs_cap <= frame_start && resetN;

  // Monitor: outputs after a strobe are checked against the queue; otherwise collision must stay low.
  always @(negedge clk) begin
    if (fs_cap) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL sb_underflow: output presented with no expected entry");
      end else begin
        cmp("frame", snap(), exp_q.pop_front());
      end
    end else if (resetN && collision !== 1'b0) begin
      n_cmp++; n_bad++;
      $display("FAIL idle_collision: got %b want 0", collision);
    end
  end

  // Between strobes the AI input is left overlapping to show it is not sampled.
  task automatic frame(input car_t a, input exp_t e);
    @(negedge clk);
    player_state = P;
    ai_state     = a;
    frame_start  = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    frame_start = 1'b0;
    ai_state    = A_HIT;
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: %0d entries left, want 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  // Full crash (60) + invulnerability (90) with overlap held the whole time.
  task automatic ride_out(input logic [2:0] l);
    for (int i = 1; i <= 60; i++)
      frame(A_HIT, (i < 60) ? mk(0, 1, 0, l, 0) : mk(0, 0, 1, l, 0));
    for (int i = 1; i <= 90; i++)
      frame(A_HIT, (i < 90) ? mk(0, 0, 1, l, 0) : mk(0, 0, 0, l, 0));
  endtask

  initial begin
    player_state = '0;
    ai_state     = '0;
    repeat (3) @(negedge clk);
    resetN = 1'b1;

    // Idle with overlapping inputs but no strobe.
    player_state = P;
    ai_state     = A_HIT;
    repeat (100) @(negedge clk);
    cmp("reset_state", snap(), mk(0, 0, 0, 3'd3, 0));

    frame(A_TOUCH_Y, mk(0, 0, 0, 3'd3, 0));
    frame(A_TOUCH_X, mk(0, 0, 0, 3'd3, 0));
    frame(A_OFF,     mk(0, 0, 0, 3'd3, 0));
    frame(A_ZERO_W,  mk(0, 0, 0, 3'd3, 0));

    frame(A_HIT, mk(1, 1, 0, 3'd2, 0));
    ride_out(3'd2);
    frame(A_HIT, mk(1, 1, 0, 3'd1, 0));
    ride_out(3'd1);
    frame(A_HIT, mk(1, 0, 0, 3'd0, 1));
    for (int i = 0; i < 3; i++) frame(A_HIT, mk(0, 0, 0, 3'd0, 1));
    drain();

    // Reset while in GAME_OVER.
    #2 resetN = 1'b0;
    #1 cmp("reset_from_game_over", snap(), mk(0, 0, 0, 3'd3, 0));
    repeat (2) @(negedge clk);
    resetN = 1'b1;

    // Hit, then 30 strobes leaves the counter at 30; reset asynchronously mid-crash.
    frame(A_HIT, mk(1, 1, 0, 3'd2, 0));
    for (int i = 0; i < 30; i++) frame(A_HIT, mk(0, 1, 0, 3'd2, 0));
    drain();
    #2 resetN = 1'b0;
    #1 cmp("async_reset_mid_crash", snap(), mk(0, 0, 0, 3'd3, 0));
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    frame(A_HIT, mk(1, 1, 0, 3'd2, 0));
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
